// File: rtl/sha256_padder.sv
// sha256_padder: upstream stage of sha256_core.
// Takes a big-endian 32-bit word stream and appends the 0x80 marker, the zero fill
// and the 64-bit message bit length. It assembles 512-bit blocks in a fill buffer
// while the core works on the previously handed block (double buffering).
module sha256_padder #(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [1:0]   in_bytes,
    input  logic         core_digest_update,
    input  logic         core_done,
    output logic         start,
    output logic         last_block,
    output logic [511:0] block,
    output logic         busy,
    output logic         err_underrun
);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        HAND,
        WAIT_DONE
    } state_t;

    state_t state, state_next;

    // Fill buffer and its bookkeeping
    logic [31:0]      fill [16];
    logic [3:0]       widx;
    logic             full;
    logic             owed;
    logic             placed;
    logic             final_blk;
    logic             msg_done;
    logic             first_blk;
    logic [LEN_W-1:0] cnt;
    logic             rdy_en;

    // Output slot bookkeeping
    logic             pending;
    logic [1:0]       init_cnt;

    // Combinational control
    logic             accept;
    logic             consume;
    logic             slot_free;
    logic             load;
    logic             pad_len;
    logic             pad_word;
    logic [2:0]       byte_inc;
    logic [31:0]      last_word;
    logic [511:0]     fill_flat;
    logic [63:0]      bit_len;

    // Handshake, hand-off and padding step decisions for the current cycle
    always_comb begin
        in_ready  = rdy_en && ((state == IDLE) || (state == FILL)) && !full;
        accept    = in_valid && in_ready;
        consume   = core_digest_update && !last_block;
        slot_free = !pending || consume;
        load      = (state == HAND) && slot_free;
        pad_len   = (state == PAD) && !full && (widx == 4'd14) && placed;
        pad_word  = (state == PAD) && !full && !pad_len;
        busy      = (state != IDLE);
        bit_len   = 64'({cnt, 3'b000});

        byte_inc = 3'd4;
        if (in_last && (in_bytes != 2'd0)) begin
            byte_inc = {1'b0, in_bytes};
        end

        last_word = in_data;
        case (in_bytes)
            2'd1:    last_word = {in_data[31:24], 8'h80, 16'h0000};
            2'd2:    last_word = {in_data[31:16], 8'h80, 8'h00};
            2'd3:    last_word = {in_data[31:8], 8'h80};
            default: last_word = in_data;
        endcase

        fill_flat = '0;
        for (int i = 0; i < 16; i++) begin
            fill_flat[511 - 32*i -: 32] = fill[i];
        end
    end

    // Next-state logic of the message FSM
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = in_last ? PAD : FILL;
                end
            end
            FILL: begin
                if (accept) begin
                    if (in_last) begin
                        state_next = PAD;
                    end else if (widx == 4'd15) begin
                        state_next = HAND;
                    end
                end
            end
            PAD: begin
                if (full || pad_len || (pad_word && (widx == 4'd15))) begin
                    state_next = HAND;
                end
            end
            HAND: begin
                if (slot_free) begin
                    if (final_blk) begin
                        state_next = WAIT_DONE;
                    end else if (msg_done) begin
                        state_next = PAD;
                    end else begin
                        state_next = FILL;
                    end
                end
            end
            WAIT_DONE: begin
                if (core_done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; in_ready stays low for the first cycle after reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_next;
            rdy_en <= 1'b1;
        end
    end

    // Fill buffer writes: message words, padding words, length words, clear on hand-off
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                fill[i] <= '0;
            end
            widx      <= '0;
            full      <= 1'b0;
            owed      <= 1'b0;
            placed    <= 1'b0;
            final_blk <= 1'b0;
            msg_done  <= 1'b0;
            first_blk <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            fill[widx] <= in_last ? last_word : in_data;
            widx       <= widx + 4'd1;
            if (widx == 4'd15) begin
                full <= 1'b1;
            end
            if (state == IDLE) begin
                cnt       <= LEN_W'(byte_inc);
                owed      <= 1'b0;
                placed    <= 1'b0;
                final_blk <= 1'b0;
                msg_done  <= 1'b0;
                first_blk <= 1'b1;
            end else begin
                cnt <= cnt + LEN_W'(byte_inc);
            end
            if (in_last) begin
                msg_done <= 1'b1;
                if (in_bytes == 2'd0) begin
                    owed <= 1'b1;
                end else begin
                    placed <= 1'b1;
                end
            end
        end else if (pad_len) begin
            fill[14]  <= bit_len[63:32];
            fill[15]  <= bit_len[31:0];
            full      <= 1'b1;
            final_blk <= 1'b1;
        end else if (pad_word) begin
            fill[widx] <= owed ? 32'h8000_0000 : 32'h0000_0000;
            if (owed) begin
                owed   <= 1'b0;
                placed <= 1'b1;
            end
            widx <= widx + 4'd1;
            if (widx == 4'd15) begin
                full <= 1'b1;
            end
        end else if (load) begin
            for (int i = 0; i < 16; i++) begin
                fill[i] <= '0;
            end
            widx      <= '0;
            full      <= 1'b0;
            final_blk <= 1'b0;
            first_blk <= 1'b0;
        end
    end

    // Output slot: block load, start pulse, pending tracking and underrun detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            block        <= '0;
            last_block   <= 1'b0;
            start        <= 1'b0;
            pending      <= 1'b0;
            init_cnt     <= '0;
            err_underrun <= 1'b0;
        end else begin
            start <= 1'b0;
            if (core_digest_update && !last_block && !pending) begin
                err_underrun <= 1'b1;
            end
            if (init_cnt != 2'd0) begin
                init_cnt <= init_cnt - 2'd1;
                if (init_cnt == 2'd1) begin
                    pending <= 1'b0;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
            if ((state == WAIT_DONE) && core_done) begin
                pending <= 1'b0;
            end
            if (load) begin
                block      <= fill_flat;
                last_block <= final_blk;
                pending    <= 1'b1;
                if (first_blk) begin
                    start        <= 1'b1;
                    init_cnt     <= 2'd2;
                    err_underrun <= 1'b0;
                end
            end
        end
    end

endmodule
